// File: rtl/ui_pkg.sv
// ui_pkg: shared types and board-rate defaults for the push-button front end.
//   btn_state_t         - per-channel event FSM state
//   DEBOUNCE_CYCLES_DEF - 20 ms stability window at the 50 MHz board clock
//   LONG_CYCLES_DEF     - 1 s long-press threshold at the 50 MHz board clock
package ui_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_t;

  localparam int BOARD_CLK_HZ        = 50_000_000;
  localparam int DEBOUNCE_CYCLES_DEF = BOARD_CLK_HZ / 50;
  localparam int LONG_CYCLES_DEF     = BOARD_CLK_HZ;

endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button channel -- 2-flop synchronizer, stability-count
// debouncer and press / long-press / release event FSM.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | debounced level is 0, waiting for a rise
// PRESSED | level is 1, long counter running toward the long threshold
// HELD    | level is 1, long event already issued, counter frozen
//
// Ports:
//   CLK         in  system clock, rising edge
//   RST_N       in  synchronous active-low reset
//   pin         in  polarity-corrected raw button (1 = pressed), async
//   level       out debounced pressed state
//   evt_press   out one-cycle pulse on level 0->1
//   evt_release out one-cycle pulse on level 1->0
//   evt_long    out one-cycle pulse once per press after the long threshold
module btn_channel
  import ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic pin,
  output logic level,
  output logic evt_press,
  output logic evt_release,
  output logic evt_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

  logic          s1, s2;
  logic [DW-1:0] db_cnt;
  logic          db_done;
  logic          rise, fall;

  btn_state_t    state, state_nxt;
  logic [LW-1:0] long_cnt, long_cnt_nxt;
  logic          press_nxt, release_nxt, long_nxt;

  // The level flips on the same edge the FSM sees rise/fall, so the FSM
  // decodes the toggle condition rather than the registered level; this
  // keeps the event pulses aligned with the level change.
  assign db_done = (s2 != level) && (db_cnt == DB_LAST);
  assign rise    = db_done && !level;
  assign fall    = db_done &&  level;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      db_cnt <= '0;
      level  <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 == level) begin
        db_cnt <= '0;
      end else if (db_done) begin
        level  <= ~level;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= IDLE;
      long_cnt    <= '0;
      evt_press   <= 1'b0;
      evt_release <= 1'b0;
      evt_long    <= 1'b0;
    end else begin
      state       <= state_nxt;
      long_cnt    <= long_cnt_nxt;
      evt_press   <= press_nxt;
      evt_release <= release_nxt;
      evt_long    <= long_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    long_cnt_nxt = long_cnt;
    press_nxt    = 1'b0;
    release_nxt  = 1'b0;
    long_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt    = PRESSED;
          long_cnt_nxt = '0;
          press_nxt    = 1'b1;
        end
      end
      PRESSED: begin
        // a release on the expiry edge suppresses the long event
        if (fall) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end else if (long_cnt == LONG_LAST) begin
          state_nxt = HELD;
          long_nxt  = 1'b1;
        end else begin
          long_cnt_nxt = long_cnt + 1'b1;
        end
      end
      HELD: begin
        if (fall) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/button_debounce.sv
// button_debounce: NBTN independent push-button conditioners producing a
// debounced level plus press / release / long-press pulses on CLK.
//
// Ports:
//   CLK         in  system clock, rising edge
//   RST_N       in  synchronous active-low reset
//   BTN_IN      in  [NBTN] raw asynchronous button pins
//   BTN_LEVEL   out [NBTN] debounced pressed state
//   BTN_PRESS   out [NBTN] one-cycle pulse on level rise
//   BTN_RELEASE out [NBTN] one-cycle pulse on level fall
//   BTN_LONG    out [NBTN] one-cycle pulse after LONG_CYCLES held
module button_debounce
  import ui_pkg::*;
#(
  parameter int NBTN            = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter bit ACTIVE_HIGH     = 1'b1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [NBTN-1:0] BTN_IN,
  output logic [NBTN-1:0] BTN_LEVEL,
  output logic [NBTN-1:0] BTN_PRESS,
  output logic [NBTN-1:0] BTN_RELEASE,
  output logic [NBTN-1:0] BTN_LONG
);

  logic [NBTN-1:0] pin;

  assign pin = ACTIVE_HIGH ? BTN_IN : ~BTN_IN;

  for (genvar g = 0; g < NBTN; g++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .pin         (pin[g]),
      .level       (BTN_LEVEL[g]),
      .evt_press   (BTN_PRESS[g]),
      .evt_release (BTN_RELEASE[g]),
      .evt_long    (BTN_LONG[g])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [2:0] BTN_IN;
  logic [2:0] BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_lvl = 3'b000;

  button_debounce #(
    .NBTN            (3),
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (16),
    .ACTIVE_HIGH     (1'b1)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .BTN_IN      (BTN_IN),
    .BTN_LEVEL   (BTN_LEVEL),
    .BTN_PRESS   (BTN_PRESS),
    .BTN_RELEASE (BTN_RELEASE),
    .BTN_LONG    (BTN_LONG)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk4(input string tag, input int i, input logic [2:0] ep,
                      input logic [2:0] er, input logic [2:0] el, input logic [2:0] elv);
    checks++;
    assert (BTN_PRESS === ep) else begin
      errors++;
      $error("FAIL %s press @%0d: got %b expected %b", tag, i, BTN_PRESS, ep);
    end
    checks++;
    assert (BTN_RELEASE === er) else begin
      errors++;
      $error("FAIL %s release @%0d: got %b expected %b", tag, i, BTN_RELEASE, er);
    end
    checks++;
    assert (BTN_LONG === el) else begin
      errors++;
      $error("FAIL %s long @%0d: got %b expected %b", tag, i, BTN_LONG, el);
    end
    checks++;
    assert (BTN_LEVEL === elv) else begin
      errors++;
      $error("FAIL %s level @%0d: got %b expected %b", tag, i, BTN_LEVEL, elv);
    end
  endtask

  // Runs n cycles after the current input setting; cycle 1 is the edge that
  // first samples it. Events on channel ch (-1 = all) are expected only at
  // the given cycle numbers (0 = never); other channels must stay quiet.
  task automatic window(input int n, input int ch, input int press_at,
                        input int rel_at, input int long_at, input string tag);
    logic [2:0] one;
    logic [2:0] m;
    one = 3'b001;
    m = (ch < 0) ? 3'b111 : (one << ch);
    for (int i = 1; i <= n; i++) begin
      cyc();
      if (i == press_at) exp_lvl = exp_lvl | m;
      if (i == rel_at)   exp_lvl = exp_lvl & ~m;
      chk4(tag, i,
           (i == press_at) ? m : 3'b000,
           (i == rel_at)   ? m : 3'b000,
           (i == long_at)  ? m : 3'b000,
           exp_lvl);
    end
  endtask

  initial begin
    // 1: reset with all buttons held, then fresh press after reset release
    RST_N  = 1'b0;
    BTN_IN = 3'b111;
    repeat (3) cyc();
    chk4("t1_reset", 0, 3'b000, 3'b000, 3'b000, 3'b000);
    RST_N = 1'b1;
    window(7, -1, 6, 0, 0, "t1_press");
    BTN_IN = 3'b000;
    window(7, -1, 0, 6, 0, "t1_release");

    // 2: clean short press on ch0
    BTN_IN[0] = 1'b1;
    window(10, 0, 6, 0, 0, "t2_press");
    BTN_IN[0] = 1'b0;
    window(8, 0, 0, 6, 0, "t2_release");

    // 3: bounce on ch1 (3-cycle runs), then stable high
    for (int k = 0; k < 10; k++) begin
      BTN_IN[1] = ~BTN_IN[1];
      window(3, 1, 0, 0, 0, "t3_bounce");
    end
    BTN_IN[1] = 1'b1;
    window(8, 1, 6, 0, 0, "t3_press");
    BTN_IN[1] = 1'b0;
    window(8, 1, 0, 6, 0, "t3_release");

    // 4: long press on ch2: long 16 cycles after press, only once
    BTN_IN[2] = 1'b1;
    window(40, 2, 6, 0, 22, "t4_long");
    BTN_IN[2] = 1'b0;
    window(8, 2, 0, 6, 0, "t4_release");

    // 5: debounced fall lands on the long-expiry edge (cycle 22 from press input)
    BTN_IN[0] = 1'b1;
    window(16, 0, 6, 0, 0, "t5_press");
    BTN_IN[0] = 1'b0;
    window(8, 0, 0, 6, 0, "t5_collide");

    // 6: reset while ch0 is HELD, button still down
    BTN_IN[0] = 1'b1;
    window(25, 0, 6, 0, 22, "t6_held");
    RST_N = 1'b0;
    cyc();
    exp_lvl[0] = 1'b0;
    chk4("t6_reset", 0, 3'b000, 3'b000, 3'b000, exp_lvl);
    RST_N = 1'b1;
    window(8, 0, 6, 0, 0, "t6_repress");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
